// File: rtl/frame_path_scheduler_pkg.sv
// Shared definitions for the frame path scheduler: FSM encoding and trailer beat layout.
// Trailer field offsets are relative to the top of the frame counter field (CNT_W).
package frame_path_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2
  } fsm_state_t;

  localparam logic [7:0] TRAILER_MARKER = 8'hA5;
  localparam int TRL_COUNT_LSB  = 0;
  localparam int TRL_ID_OFS     = 0;
  localparam int TRL_MARKER_OFS = 8;
  localparam int TRL_FIELD_W    = 8;

endpackage

// File: rtl/frame_path_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// (last_grant+1) mod N_SRC.
module rr_arbiter #(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] last_grant,
  output logic [$clog2(N_SRC)-1:0] grant,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(N_SRC);

  int unsigned      idx;
  logic [IDX_W-1:0] idx_sel;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx     = (int'(last_grant) + off) % N_SRC;
      idx_sel = IDX_W'(idx);
      if (!any_req && req[idx_sel]) begin
        any_req = 1'b1;
        grant   = idx_sel;
      end
    end
  end

endmodule

// File: rtl/frame_path_scheduler.sv
// Shares one AXI-Stream output between N_SRC sources, one framed grant at a time:
// FRAME_BEATS payload beats passed through combinationally, then a trailer beat.
module frame_path_scheduler
  import frame_path_scheduler_pkg::*;
#(
  parameter int DW          = 128,
  parameter int N_SRC       = 2,
  parameter int FRAME_BEATS = 128,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_SRC*DW-1:0]        s_tdata,
  input  logic [N_SRC-1:0]           s_tvalid,
  output logic [N_SRC-1:0]           s_tready,
  output logic [DW-1:0]              m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [DW/8-1:0]            m_tkeep,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic [CNT_W-1:0]           frame_count,
  output logic [1:0]                 fsm_state
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int BCW   = $clog2(FRAME_BEATS + 1);

  fsm_state_t       state_reg;
  logic [IDX_W-1:0] grant_id_reg;
  logic [IDX_W-1:0] last_grant_reg;
  logic [BCW-1:0]   beat_cnt_reg;
  logic [CNT_W-1:0] frame_count_reg;

  logic [IDX_W-1:0] arb_grant;
  logic             arb_any;
  logic [DW-1:0]    trailer_data;
  logic             src_valid;
  logic [DW-1:0]    src_data;

  rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req        (s_tvalid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  assign src_valid = s_tvalid[grant_id_reg];
  assign src_data  = s_tdata[grant_id_reg*DW +: DW];

  always_comb begin
    trailer_data = '0;
    trailer_data[TRL_COUNT_LSB +: CNT_W]               = frame_count_reg;
    trailer_data[CNT_W + TRL_ID_OFS +: TRL_FIELD_W]    = TRL_FIELD_W'(grant_id_reg);
    trailer_data[CNT_W + TRL_MARKER_OFS +: TRL_FIELD_W] = TRAILER_MARKER;
  end

  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    case (state_reg)
      ST_PAYLOAD: begin
        m_tvalid = src_valid;
        m_tdata  = src_data;
      end
      ST_TRAILER: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tdata  = trailer_data;
      end
      default: ;
    endcase
  end

  assign m_tkeep = {(DW/8){m_tvalid}};

  // Only the granted source sees ready, and only while its payload is flowing.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
    assign s_tready[gi] = (state_reg == ST_PAYLOAD) && (grant_id_reg == IDX_W'(gi)) && m_tready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      grant_id_reg    <= '0;
      last_grant_reg  <= IDX_W'(N_SRC - 1);
      beat_cnt_reg    <= '0;
      frame_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_any) begin
            grant_id_reg <= arb_grant;
            beat_cnt_reg <= '0;
            state_reg    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (m_tvalid && m_tready) begin
            beat_cnt_reg <= beat_cnt_reg + BCW'(1);
            if (beat_cnt_reg == BCW'(FRAME_BEATS - 1))
              state_reg <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (m_tready) begin
            frame_count_reg <= frame_count_reg + CNT_W'(1);
            last_grant_reg  <= grant_id_reg;
            state_reg       <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign grant_id    = grant_id_reg;
  assign frame_count = frame_count_reg;
  assign fsm_state   = state_reg;

endmodule

// File: doc/frame_path_scheduler.md
# frame_path_scheduler

Round-robin scheduler that shares a single AXI-Stream output between N_SRC payload paths, framing each grant. Each grant forwards exactly FRAME_BEATS payload beats from one source, then appends one trailer beat carrying the source id and a running frame count, with tlast set. It sits upstream of the transmit datapath, in front of the ping-pong path group, and decides which path owns the output for each frame.

## Interface
- DW, 128, data width in bits, multiple of 8, at least CNT_W+16
- N_SRC, 2, number of payload sources, 2..16
- FRAME_BEATS, 128, payload beats per frame, at least 1
- CNT_W, 32, frame counter width
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- s_tdata  in  N_SRC*DW  source i occupies bits [i*DW +: DW]
- s_tvalid  in  N_SRC  per-source valid
- s_tready  out  N_SRC  per-source ready
- m_tdata  out  DW  output data
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  high on trailer beat only
- m_tkeep  out  DW/8  all ones whenever m_tvalid, else 0
- grant_id  out  $clog2(N_SRC)  currently or last granted source
- frame_count  out  CNT_W  completed frames since reset
- fsm_state  out  2  IDLE=0, PAYLOAD=1, TRAILER=2

## Operation
- Accept means valid and ready are both high on a clock edge. Beat counter beat_cnt has width $clog2(FRAME_BEATS+1).
- IDLE:
  - All s_tready are 0, m_tvalid is 0.
  - If any s_tvalid is high, grant the first requester at or after (last_grant+1) mod N_SRC, register it into grant_id, clear beat_cnt, and go to PAYLOAD.
  - last_grant resets to N_SRC-1, so the first grant search starts at source 0.
- PAYLOAD:
  - m_tdata, m_tvalid and m_tkeep follow the granted source combinationally.
  - s_tready[grant_id] = m_tready. All other s_tready are 0.
  - On each accept, beat_cnt increments. The accept that makes FRAME_BEATS beats moves the block to TRAILER.
  - If the granted source's valid drops, the block waits in PAYLOAD. It never re-arbitrates mid-frame.
- TRAILER:
  - m_tvalid=1, m_tlast=1, all s_tready=0.
  - m_tdata: [CNT_W-1:0] = frame_count, [CNT_W+7:CNT_W] = zero-extended grant_id, [CNT_W+15:CNT_W+8] = 8'hA5, all remaining bits 0.
  - On accept: frame_count increments, wrapping from 2^CNT_W-1 to 0; last_grant takes grant_id; state goes to IDLE.
  - m_tdata is held stable while m_tready is low.
- Reset values: fsm_state=IDLE, grant_id=0, frame_count=0, beat_cnt=0, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, all s_tready=0.
- Reset mid-frame abandons the partial frame. No trailer is emitted, and frame_count does not advance.

## Timing
- IDLE to PAYLOAD takes 1 cycle. The first payload beat can be accepted on the cycle after the grant decision.
- The payload path has zero latency: it is combinational from s_* to m_*, with no payload registers.
- Back-to-back: a full frame occupies at least 1 + FRAME_BEATS + 1 cycles (IDLE, payload beats, trailer).
- A requester that is continuously valid is granted at most once per N_SRC frames while others are requesting.
- TRAILER holds indefinitely under m_tready=0.

## Structure
- Shared package holds:
  - the state encoding (IDLE/PAYLOAD/TRAILER)
  - the trailer field offsets
  - TRAILER_MARKER = 8'hA5
- Sub-module rr_arbiter:
  - inputs: request vector and last_grant
  - outputs: a grant index and an any_req flag
  - purely combinational, parameterised by N_SRC, reusable elsewhere.

## Test plan
- N_SRC=2, FRAME_BEATS=4, source 0 only, always valid, m_tready=1: output is 4 payload beats equal to s_tdata[0], then a trailer with count=0, id=0, marker A5, tlast=1. The next frame's trailer has count=1.
- Both sources always valid: grants alternate 0,1,0,1. Trailers carry ids 0,1,0,1 and counts 0,1,2,3. The non-granted s_tready is 0 throughout.
- m_tready toggled 1,0,1,0 during payload and trailer: no beat is lost or duplicated, and trailer data stays stable while stalled.
- Granted source drops valid for 3 cycles mid-frame while the other source is valid: the scheduler stays on the granted source and finishes its 4 beats before switching.
- CNT_W=4: after 16 frames, frame_count wraps to 0 and the 17th trailer shows count 0.
- Reset asserted after 2 payload beats: the next cycle shows IDLE and all outputs at reset values. After release, a full frame is emitted with count 0 from source 0.
